// File: rtl/lane_skew_delay_pkg.sv
// -----------------------------------------------------------------------------
// lane_skew_delay_pkg
// Shared definitions for the NTT lane re-skew block: lane count, coefficient
// width, the packed lane bundle type, the control FSM encoding and the
// per-lane delay helper.
// Optional feature macro used by the top: LANE_SKEW_BYPASS_EN.
// -----------------------------------------------------------------------------
package lane_skew_delay_pkg;

  localparam int LANES  = 8;
  localparam int COEF_W = 16;

  // One coefficient per lane; lane 0 is the least significant slice.
  typedef logic [LANES-1:0][COEF_W-1:0] lane_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN
  } state_t;

  // Delay of lane i in valid beats. Descending order (ascend=0) makes the
  // highest lane the zero-delay lane.
  function automatic int skew_delay(input int i, input int step, input bit ascend);
    return ascend ? i * step : (LANES - 1 - i) * step;
  endfunction

endpackage

// File: rtl/lane_skew_delay_lane_shift_reg.sv
// -----------------------------------------------------------------------------
// lane_shift_reg
// Gated shift register for one lane. Advances only when en=1; zero_ins
// replaces the incoming word with zero (used while draining). DEPTH=0 is a
// pure passthrough so the caller can treat every lane uniformly.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   en        shift enable
//   zero_ins  insert zero at the tail instead of din
//   din       incoming lane word
//   dout      word leaving the line (value to capture on this shift)
// -----------------------------------------------------------------------------
module lane_shift_reg #(
  parameter int DEPTH = 1,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         zero_ins,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] tail;
  assign tail = zero_ins ? '0 : din;

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst, en};
    assign dout = tail;
  end else begin : g_reg
    logic [DEPTH-1:0][W-1:0] sr;

    // NOTE: the delay line is cleared on reset on purpose: a drain after a
    // partial fill must emit zeros, not stale data, for the unfilled taps.
    always_ff @(posedge clk) begin
      if (rst) begin
        sr <= '0;
      end else if (en) begin
        sr[0] <= tail;
        for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/lane_skew_delay.sv
// -----------------------------------------------------------------------------
// lane_skew_delay
// Per-lane gated delay line realigning the diagonal words of the stage-1
// commutator into column order. Lane i is delayed by skew_delay(i) valid
// beats; the block tracks fill, supports an explicit drain (flush) and an
// end-of-transform clear (nttend).
// Optional feature: define LANE_SKEW_BYPASS_EN to add the bypass input, which
// passes lane_in/valid_in straight to the output registers and freezes the
// delay lines and FSM while asserted.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   valid_in   lane_in carries a valid beat
//   lane_in    input lanes
//   flush      start draining held data (pulse)
//   nttend     clear control state (data registers kept)
//   bypass     (LANE_SKEW_BYPASS_EN only) direct passthrough
//   lane_out   realigned lanes, registered
//   valid_out  lane_out is a complete aligned word
//   busy       block is in FILL, RUN or DRAIN
//   drop_err   pulse when valid_in arrives during DRAIN
// -----------------------------------------------------------------------------
module lane_skew_delay
  import lane_skew_delay_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int STEP   = 1,
  parameter bit ASCEND = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  valid_in,
  input  lane_t lane_in,
  input  logic  flush,
  input  logic  nttend,
`ifdef LANE_SKEW_BYPASS_EN
  input  logic  bypass,
`endif
  output lane_t lane_out,
  output logic  valid_out,
  output logic  busy,
  output logic  drop_err
);

  localparam int MAXD  = (LANES - 1) * STEP;
  localparam int CNT_W = (MAXD > 0) ? $clog2(MAXD + 1) : 1;
  localparam logic [CNT_W-1:0] MAXD_C = CNT_W'(MAXD);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] fill_cnt, fill_nx, fill_inc;
  logic [CNT_W-1:0] drain_cnt, drain_nx;
  logic             shift, zero_ins, valid_nx, drop_nx;
  logic             frozen;
  lane_t            tap;

`ifdef LANE_SKEW_BYPASS_EN
  assign frozen = bypass;
`else
  assign frozen = 1'b0;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_shift_reg #(
      .DEPTH(skew_delay(i, STEP, ASCEND)),
      .W    (COEF_W)
    ) u_sr (
      .clk     (clk),
      .rst     (rst),
      .en      (shift),
      .zero_ins(zero_ins),
      .din     (lane_in[i]),
      .dout    (tap[i])
    );
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      fill_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nx;
      fill_cnt  <= fill_nx;
      drain_cnt <= drain_nx;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    fill_nx  = fill_cnt;
    drain_nx = drain_cnt;
    shift    = 1'b0;
    zero_ins = 1'b0;
    valid_nx = 1'b0;
    drop_nx  = 1'b0;
    fill_inc = fill_cnt + ONE_C;

    if (frozen) begin
      // Delay lines and counters hold; outputs are overridden downstream.
    end else if (nttend) begin
      state_nx = S_IDLE;
      fill_nx  = '0;
      drain_nx = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (valid_in) begin
            shift = 1'b1;
            if (MAXD == 0) begin
              state_nx = S_RUN;
            end else begin
              fill_nx  = ONE_C;
              state_nx = (ONE_C == MAXD_C) ? S_RUN : S_FILL;
            end
          end
        end
        S_FILL: begin
          // A beat arriving with flush is counted before the drain starts.
          if (valid_in) begin
            shift   = 1'b1;
            fill_nx = fill_inc;
          end
          if (flush) begin
            state_nx = S_DRAIN;
            drain_nx = fill_nx;
          end else if (fill_nx == MAXD_C) begin
            state_nx = S_RUN;
          end
        end
        S_RUN: begin
          if (valid_in) begin
            shift    = 1'b1;
            valid_nx = 1'b1;
          end
          if (flush) begin
            if (MAXD == 0) begin
              state_nx = S_IDLE;
              fill_nx  = '0;
            end else begin
              state_nx = S_DRAIN;
              drain_nx = MAXD_C;
            end
          end
        end
        S_DRAIN: begin
          // Shift zeros in every cycle; incoming beats are refused.
          shift    = 1'b1;
          zero_ins = 1'b1;
          valid_nx = 1'b1;
          drop_nx  = valid_in;
          drain_nx = drain_cnt - ONE_C;
          if (drain_cnt == ONE_C) begin
            state_nx = S_IDLE;
            fill_nx  = '0;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_out  <= '0;
      valid_out <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      valid_out <= valid_nx;
      drop_err  <= drop_nx;
      if (shift) lane_out <= tap;
`ifdef LANE_SKEW_BYPASS_EN
      if (bypass) begin
        lane_out  <= lane_in;
        valid_out <= valid_in;
      end
`endif
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_lane_skew_delay.sv
// -----------------------------------------------------------------------------
// tb_lane_skew_delay
// Self-checking bench for lane_skew_delay (default parameters). A behavioural
// model keeps, per lane, the full history of words shifted in since reset and
// derives each output as the word delay_j shift cycles old. Directed
// scenarios pin the model with hand-computed values; a random phase follows.
// With LANE_SKEW_BYPASS_EN defined the bypass port is driven as well.
// -----------------------------------------------------------------------------
module tb_lane_skew_delay;
  import lane_skew_delay_pkg::*;

  localparam int MAXD = LANES - 1;
  localparam int M_IDLE = 0, M_FILL = 1, M_RUN = 2, M_DRAIN = 3;
  typedef logic [$bits(lane_t)-1:0] wide_t;

  logic  clk = 1'b0;
  logic  rst, valid_in, flush, nttend, bypass;
  lane_t lane_in, lane_out;
  logic  valid_out, busy, drop_err;

  int checks   = 0;
  int failures = 0;

  // Model state
  int               m_mode, m_fill, m_drain;
  lane_t            exp_lane;
  logic             exp_valid, exp_derr;
  logic [COEF_W-1:0] hist[LANES][$];

  lane_skew_delay dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .lane_in  (lane_in),
    .flush    (flush),
    .nttend   (nttend),
`ifdef LANE_SKEW_BYPASS_EN
    .bypass   (bypass),
`endif
    .lane_out (lane_out),
    .valid_out(valid_out),
    .busy     (busy),
    .drop_err (drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input wide_t act, input wide_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic lane_t ramp(input int n);
    lane_t r;
    for (int j = 0; j < LANES; j++) r[j] = COEF_W'(64 * j + n);
    return r;
  endfunction

  // Expected outputs after the next clock edge for the given inputs.
  task automatic model_step(input bit v, input bit f, input bit e, input bit r,
                            input bit b, input lane_t d);
    bit sh, zi;
    sh = 1'b0;
    zi = 1'b0;
    if (r) begin
      m_mode = M_IDLE; m_fill = 0; m_drain = 0;
      exp_lane = '0; exp_valid = 1'b0; exp_derr = 1'b0;
      foreach (hist[j]) hist[j].delete();
      return;
    end
    if (b) begin
      exp_lane = d; exp_valid = v; exp_derr = 1'b0;
      return;
    end
    exp_valid = 1'b0;
    exp_derr  = 1'b0;
    if (e) begin
      m_mode = M_IDLE; m_fill = 0; m_drain = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (v) begin
          sh = 1'b1; m_fill = 1;
          m_mode = (m_fill >= MAXD) ? M_RUN : M_FILL;
        end
        M_FILL: begin
          if (v) begin sh = 1'b1; m_fill++; end
          if (f) begin m_mode = M_DRAIN; m_drain = m_fill; end
          else if (m_fill == MAXD) m_mode = M_RUN;
        end
        M_RUN: begin
          if (v) begin sh = 1'b1; exp_valid = 1'b1; end
          if (f) begin m_mode = M_DRAIN; m_drain = MAXD; end
        end
        default: begin
          sh = 1'b1; zi = 1'b1; exp_valid = 1'b1; exp_derr = v;
          m_drain--;
          if (m_drain == 0) begin m_mode = M_IDLE; m_fill = 0; end
        end
      endcase
    end
    if (sh) begin
      for (int j = 0; j < LANES; j++) begin
        int idx;
        hist[j].push_back(zi ? '0 : d[j]);
        idx = hist[j].size() - 1 - (LANES - 1 - j);
        exp_lane[j] = (idx >= 0) ? hist[j][idx] : '0;
      end
    end
  endtask

  task automatic compare_all();
    check("valid_out", valid_out, exp_valid);
    check("busy", busy, m_mode != M_IDLE);
    check("drop_err", drop_err, exp_derr);
    check("lane_out", lane_out, exp_lane);
  endtask

  task automatic tick(input bit v, input bit f, input bit e, input bit r, input lane_t d);
    valid_in = v; flush = f; nttend = e; rst = r; lane_in = d;
    model_step(v, f, e, r, bypass, d);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    lane_t cont_q[$], slow_q[$];
    lane_t rnd, bv;
    int    first, nd, nv, ne, last4;

    rst = 1'b1; valid_in = 1'b0; flush = 1'b0; nttend = 1'b0;
    bypass = 1'b0; lane_in = '0;

    // Reset state
    tick(0, 0, 0, 1, '0);
    tick(0, 0, 0, 1, '0);
    check("rst_lane_out", lane_out, '0);
    check("rst_valid_out", valid_out, 0);
    check("rst_busy", busy, 0);

    // Continuous beats
    tick(0, 0, 0, 0, '0);
    first = -1;
    for (int n = 0; n < 16; n++) begin
      tick(1, 0, 0, 0, ramp(n));
      if (valid_out) begin
        if (first < 0) begin
          first = n;
          check("first_word_lane7", lane_out[7], 455);
          check("first_word_lane0", lane_out[0], 0);
          check("first_word_lane3", lane_out[3], 195);
        end
        cont_q.push_back(lane_out);
      end
    end
    check("first_valid_beat", first, 7);

    // One beat in three
    tick(0, 0, 0, 1, '0);
    for (int n = 0; n < 16; n++) begin
      tick(0, 0, 0, 0, '0);
      tick(0, 0, 0, 0, '0);
      tick(1, 0, 0, 0, ramp(n));
      if (valid_out) slow_q.push_back(lane_out);
    end
    check("slow_word_count", slow_q.size(), cont_q.size());
    for (int k = 0; k < slow_q.size() && k < cont_q.size(); k++)
      check("slow_vs_cont", slow_q[k], cont_q[k]);

    // Flush from RUN
    tick(0, 1, 0, 0, '0);
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      tick(0, 0, 0, 0, '0);
      if (valid_out) begin
        check("run_drain_lane7", lane_out[7], 0);
        check("run_drain_lane0", lane_out[0], 9 + nd);
        nd++;
      end
    end
    check("run_drain_count", nd, 7);
    check("run_drain_idle", busy, 0);

    // Flush from FILL with a beat injected mid-drain
    tick(0, 0, 0, 1, '0);
    for (int n = 0; n < 3; n++) tick(1, 0, 0, 0, ramp(n));
    tick(0, 1, 0, 0, '0);
    nd = 0; ne = 0; last4 = -1;
    for (int k = 0; k < 6; k++) begin
      tick(k == 1, 0, 0, 0, ramp(99));
      if (valid_out) begin nd++; last4 = lane_out[4]; end
      if (drop_err) ne++;
    end
    check("fill_drain_count", nd, 3);
    check("fill_drop_err_pulses", ne, 1);
    check("fill_drain_last_lane4", last4, 258);
    check("fill_drain_idle", busy, 0);

    // nttend in RUN with a concurrent beat
    tick(0, 0, 0, 1, '0);
    for (int n = 0; n < 10; n++) tick(1, 0, 0, 0, ramp(n));
    tick(1, 0, 1, 0, ramp(10));
    check("ntt_busy", busy, 0);
    check("ntt_valid_out", valid_out, 0);
    nv = 0;
    for (int n = 0; n < 8; n++) begin
      tick(1, 0, 0, 0, ramp(11 + n));
      if (n < 7 && valid_out) nv++;
    end
    check("ntt_quiet_beats", nv, 0);
    check("ntt_resume", valid_out, 1);

`ifdef LANE_SKEW_BYPASS_EN
    // Bypass while in FILL: outputs follow inputs, FSM frozen
    tick(0, 0, 0, 1, '0);
    for (int n = 0; n < 3; n++) tick(1, 0, 0, 0, ramp(n));
    bypass = 1'b1;
    for (int j = 0; j < LANES; j++) bv[j] = COEF_W'(j + 1);
    tick(1, 0, 0, 0, bv);
    check("bypass_lane_out", lane_out, bv);
    check("bypass_valid_hi", valid_out, 1);
    tick(0, 0, 0, 0, bv);
    check("bypass_valid_lo", valid_out, 0);
    bypass = 1'b0;
    check("bypass_fill_held", dut.fill_cnt, 3);
    for (int n = 3; n < 10; n++) tick(1, 0, 0, 0, ramp(n));
`endif

    // Random traffic
    tick(0, 0, 0, 1, '0);
    for (int k = 0; k < 600; k++) begin
      for (int j = 0; j < LANES; j++) rnd[j] = COEF_W'($urandom);
      tick($urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 199) == 0, rnd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
